cnt_bcd_display: RTL and testbench
==================================

Name: cnt_bcd_display

Overview:
Downstream consumer of the 6-bit mod-41 counter value. Converts the binary count to two BCD digits with a sequential shift-add-3 (double-dabble) engine and time-multiplexes them onto a 2-digit common-anode seven-segment display. Also flags counter wrap (MAX_VAL→0) and out-of-range input values.

Parameters:
MAX_VAL, 40, terminal count of the upstream counter; used for wrap detect and range check
SCAN_DIV, 4, clocks each digit is displayed before the scan switches digit (≥2)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous reset, active-high
cnt_in  input  6  binary count from upstream counter
bcd_tens  output  4  converted tens digit
bcd_ones  output  4  converted ones digit
busy  output  1  conversion in progress
range_err  output  1  last converted value > MAX_VAL
wrap  output  1  one-cycle pulse on counter wrap
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
an  output  2  digit enables, active-low; an[0]=ones, an[1]=tens

Behaviour:
- All outputs and state registered; all updates on rising clk.
- Reset (rst=1 at an edge, any state, including mid-conversion): FSM→IDLE, bcd_tens=0, bcd_ones=0, busy=0, range_err=0, wrap=0, last_val=0, prev_cnt=0, scan counter=0, an=2'b10, seg=7'b1000000 (digit '0'). A conversion in progress is abandoned.
- FSM states IDLE, CONV, DONE:
  - IDLE: if cnt_in != last_val → latch cnt_in into shift register, clear 8-bit BCD accumulator, iter=0, busy=1, →CONV. Otherwise stay.
  - CONV: per cycle, add 3 to each BCD nibble ≥5, then shift {bcd,bin} left by 1; iter++. After the 6th shift →DONE.
  - DONE: load bcd_tens/bcd_ones; last_val=latched value; range_err=(latched > MAX_VAL); busy=0; →IDLE.
- Latency: cnt_in sampled at edge k → bcd_* valid after edge k+7. busy is high after edges k..k+6 and low after edge k+7.
- cnt_in changes while busy are ignored. On return to IDLE the current cnt_in is compared with last_val, and a new conversion starts if they differ. The display therefore tracks at most one value per 8 clocks.
- Conversion covers the full 0..63 range: bcd_tens is 0..6, and 41..63 convert correctly with range_err=1.
- Wrap detect runs independently of the FSM: prev_cnt<=cnt_in every cycle. wrap=1 for exactly one cycle after the edge where prev_cnt==MAX_VAL and cnt_in==0. A 0→0 hold or a jump from another value to 0 gives no pulse.
- Scan:
  - Counter runs 0..SCAN_DIV-1. When it is at SCAN_DIV-1 it returns to 0 and an toggles 2'b10↔2'b01.
  - seg is registered with an, showing the digit selected by the new an value.
  - Digit change period is SCAN_DIV clocks; full refresh is 2*SCAN_DIV.
- Segment encoding, active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other code gives 1111111 (blank).

Optional Feature:
CNT_BCD_BLANK_LEAD_ZERO_EN
- Defined: when bcd_tens==0, the tens digit phase drives seg=7'b1111111 (blank). an still scans normally.
- Undefined: the tens digit shows '0' (7'b1000000).
- bcd_* outputs are identical in both builds.

Test Plan:
- Reset: rst=1 for 2 clocks with cnt_in=25 → bcd_tens=0, bcd_ones=0, busy=0, wrap=0, an=2'b10, seg=7'b1000000. After rst=0, busy rises at the next edge.
- Single conversion: hold cnt_in=37 → busy high 7 cycles, then bcd_tens=3, bcd_ones=7, range_err=0. Ones phase seg=7'b1111000; tens phase seg=7'b0110000.
- Back-to-back change: cnt_in=12, then 13 three cycles later → 12 is completed first (tens=1, ones=2). A second conversion starts on the edge after DONE, and final bcd=1,3.
- Range: cnt_in=63 → bcd_tens=6, bcd_ones=3, range_err=1. Then cnt_in=40 → range_err=0.
- Wrap: drive cnt_in 39,40,0,1 on consecutive clocks → wrap high exactly one cycle, after the 40→0 edge. Drive 5→0 → wrap stays 0.
- Scan and leading zero: cnt_in=7, SCAN_DIV=4 → an toggles every 4 clocks. Tens phase seg=7'b1000000 without the macro and 7'b1111111 with it defined.

Source files
------------

// File: rtl/cnt_bcd_display.sv
// Binary count to two-digit BCD (serial double-dabble) with a scanned 7-seg display.
// Optional build macro: CNT_BCD_BLANK_LEAD_ZERO_EN blanks a zero tens digit.
module cnt_bcd_display #(
    parameter int MAX_VAL  = 40,
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] cnt_in,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       busy,
    output logic       range_err,
    output logic       wrap,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [5:0] bin_q, bin_d;
    logic [7:0] acc_q, acc_d;
    logic [2:0] iter_q, iter_d;
    logic [5:0] lat_q, lat_d;
    logic [5:0] last_q, last_d;
    logic [5:0] prev_q;
    logic [3:0] tens_d, ones_d;
    logic       busy_d, err_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [1:0] an_d;
    logic [6:0] seg_d;
    logic [3:0] digit;

    function automatic logic [7:0] add3(input logic [7:0] b);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = b[7:4];
        lo = b[3:0];
        if (hi >= 4'd5) hi = hi + 4'd3;
        if (lo >= 4'd5) lo = lo + 4'd3;
        return {hi, lo};
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Conversion FSM next-state and datapath
    always_comb begin
        state_nx = state;
        bin_d    = bin_q;
        acc_d    = acc_q;
        iter_d   = iter_q;
        lat_d    = lat_q;
        last_d   = last_q;
        tens_d   = bcd_tens;
        ones_d   = bcd_ones;
        busy_d   = busy;
        err_d    = range_err;
        unique case (state)
            IDLE: begin
                if (cnt_in != last_q) begin
                    bin_d    = cnt_in;
                    lat_d    = cnt_in;
                    acc_d    = 8'd0;
                    iter_d   = 3'd0;
                    busy_d   = 1'b1;
                    state_nx = CONV;
                end
            end
            CONV: begin
                {acc_d, bin_d} = {add3(acc_q), bin_q} << 1;
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd5) state_nx = DONE;
            end
            DONE: begin
                tens_d   = acc_q[7:4];
                ones_d   = acc_q[3:0];
                last_d   = lat_q;
                err_d    = (int'(lat_q) > MAX_VAL);
                busy_d   = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Scan timing; seg follows the digit picked by the next an value
    always_comb begin
        scan_d = scan_q + SW'(1);
        an_d   = an;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            an_d   = ~an;
        end
        digit = an_d[0] ? bcd_tens : bcd_ones;
        seg_d = enc(digit);
`ifdef CNT_BCD_BLANK_LEAD_ZERO_EN
        if (an_d[0] && bcd_tens == 4'd0) seg_d = 7'b1111111;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bin_q     <= '0;
            acc_q     <= '0;
            iter_q    <= '0;
            lat_q     <= '0;
            last_q    <= '0;
            prev_q    <= '0;
            bcd_tens  <= '0;
            bcd_ones  <= '0;
            busy      <= 1'b0;
            range_err <= 1'b0;
            wrap      <= 1'b0;
            scan_q    <= '0;
            an        <= 2'b10;
            seg       <= 7'b1000000;
        end else begin
            state     <= state_nx;
            bin_q     <= bin_d;
            acc_q     <= acc_d;
            iter_q    <= iter_d;
            lat_q     <= lat_d;
            last_q    <= last_d;
            prev_q    <= cnt_in;
            bcd_tens  <= tens_d;
            bcd_ones  <= ones_d;
            busy      <= busy_d;
            range_err <= err_d;
            wrap      <= (int'(prev_q) == MAX_VAL) && (cnt_in == 6'd0);
            scan_q    <= scan_d;
            an        <= an_d;
            seg       <= seg_d;
        end
    end

endmodule

// File: tb/tb_cnt_bcd_display.sv
// Randomized bench for cnt_bcd_display against a cycle-level behavioural model.
// Define CNT_BCD_BLANK_LEAD_ZERO_EN on both DUT and bench to test blanking.
module tb_cnt_bcd_display;

    localparam int MAXV = 40;
    localparam int SDIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] cnt_in;
    logic [3:0] bcd_tens, bcd_ones;
    logic       busy, range_err, wrap;
    logic [6:0] seg;
    logic [1:0] an;

    cnt_bcd_display #(.MAX_VAL(MAXV), .SCAN_DIV(SDIV)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in),
        .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
        .busy(busy), .range_err(range_err), .wrap(wrap),
        .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference state, expressed as "value in flight + cycles left"
    int m_left, m_lat, m_last, m_prev, m_n;
    int m_tens, m_ones;
    bit m_busy, m_err, m_wrap;
    logic [1:0] m_an;
    logic [6:0] m_seg;

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (d >= 0 && d < 10) ? tbl[d] : 7'b1111111;
    endfunction

    task automatic model_step(input bit r, input int v);
        if (r) begin
            m_left = 0; m_lat = 0; m_last = 0; m_prev = 0; m_n = 0;
            m_tens = 0; m_ones = 0; m_busy = 0; m_err = 0; m_wrap = 0;
            m_an = 2'b10; m_seg = 7'b1000000;
            return;
        end
        m_wrap = (m_prev == MAXV) && (v == 0);
        m_prev = v;
        m_n++;
        m_an = ((m_n / SDIV) % 2 == 1) ? 2'b01 : 2'b10;
        m_seg = seg_of(m_an == 2'b10 ? m_ones : m_tens);
`ifdef CNT_BCD_BLANK_LEAD_ZERO_EN
        if (m_an == 2'b01 && m_tens == 0) m_seg = 7'b1111111;
`endif
        if (m_left == 0) begin
            if (v != m_last) begin
                m_lat = v;
                m_left = 7;
                m_busy = 1;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_tens = m_lat / 10;
                m_ones = m_lat % 10;
                m_last = m_lat;
                m_err = m_lat > MAXV;
                m_busy = 0;
            end
        end
    endtask

    task automatic cyc(input bit r, input int v);
        rst = r;
        cnt_in = 6'(v);
        @(posedge clk);
        model_step(r, v);
        #1;
        chk("tens", 32'(bcd_tens), 32'(m_tens));
        chk("ones", 32'(bcd_ones), 32'(m_ones));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("range_err", 32'(range_err), 32'(m_err));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("an", 32'(an), 32'(m_an));
        chk("seg", 32'(seg), 32'(m_seg));
    endtask

    task automatic hold(input int v, input int n);
        for (int i = 0; i < n; i++) cyc(0, v);
    endtask

    initial begin
        rst = 1'b1;
        cnt_in = 6'd25;
        cyc(1, 25);
        cyc(1, 25);
        hold(25, 10);
        hold(37, 20);
        hold(12, 3);
        hold(13, 20);
        hold(63, 12);
        hold(40, 12);
        cyc(0, 39); cyc(0, 40); cyc(0, 0); cyc(0, 1);
        hold(5, 3); cyc(0, 0); hold(0, 3);
        hold(7, 24);
        cyc(0, 20); cyc(0, 21);
        cyc(1, 21);
        hold(21, 12);
        for (int s = 0; s < 80; s++) begin
            int mode;
            mode = $urandom_range(0, 9);
            if (mode < 6) begin
                hold($urandom_range(0, 63), $urandom_range(1, 12));
            end else if (mode < 8) begin
                cyc(0, 39); cyc(0, 40); cyc(0, 0);
            end else if (mode == 8) begin
                for (int k = 0; k < 5; k++) cyc(0, $urandom_range(0, 63));
            end else begin
                cyc(1, $urandom_range(0, 63));
            end
        end
        hold(9, 12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
